ahb_trans_fifo: RTL

AHB_TRANS_FIFO -- requirements
Module: ahb_trans_fifo

---
 rtl/ahb_trans_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ahb_trans_fifo.sv
// ---------------------------------------------------------------------------
// ahb_trans_fifo
// Buffers AHB transaction records {write, size, addr, data} between a
// producer and a consumer. The read side works in one of two modes:
// first-word-fall-through (the head record is always visible), or
// registered (the head record appears one cycle after a pop).
//
// Ports
//   clk, resetn         clock; asynchronous active-low reset
//   clr                 synchronous flush (pointers, sticky flags, rd_valid)
//   wr_en, wr_*         push request and the record to store
//   rd_en               pop request (acknowledge of the head in FWFT mode)
//   rd_*, rd_valid      head record and its qualifier
//   full, almost_full,
//   empty, count        occupancy status
//   overflow, underflow sticky error flags, cleared by clr or reset
// ---------------------------------------------------------------------------
module ahb_trans_fifo #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 1,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic                     wr_write,
    input  logic [2:0]               wr_size,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic                     rd_write,
    output logic [2:0]               rd_size,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] AFULL_C = PTR_W'(AFULL_LVL);

    typedef struct packed {
        logic              write;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             wr_rec;
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_acc;
    logic             wr_acc;

    // The extra pointer MSB separates "same index, empty" from
    // "same index, wrapped once, full".
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                         (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= AFULL_C);

    // A push into a full FIFO is accepted only when a pop frees a slot in
    // the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    assign wr_rec = '{write: wr_write, size: wr_size, addr: wr_addr, data: wr_data};
    assign head   = mem[rd_ptr[IDX_W-1:0]];

    // Pointer and sticky-flag state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !wr_acc)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; entries are only observable
    // between the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr)
            mem[wr_ptr[IDX_W-1:0]] <= wr_rec;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head shown straight from the array; empty comes from registered
            // pointers, so a fresh write is visible only from the next cycle.
            assign rd_valid = !empty;
            assign rd_write = head.write;
            assign rd_size  = head.size;
            assign rd_addr  = head.addr;
            assign rd_data  = head.data;
        end else begin : g_reg
            rec_t rd_rec_p1;
            logic vld_p1;

            // Stage p1: head captured on pop, qualified for exactly one cycle
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    rd_rec_p1 <= '0;
                    vld_p1    <= 1'b0;
                end else if (clr) begin
                    vld_p1    <= 1'b0;
                end else begin
                    vld_p1 <= rd_acc;
                    if (rd_acc)
                        rd_rec_p1 <= head;
                end
            end

            assign rd_valid = vld_p1;
            assign rd_write = rd_rec_p1.write;
            assign rd_size  = rd_rec_p1.size;
            assign rd_addr  = rd_rec_p1.addr;
            assign rd_data  = rd_rec_p1.data;
        end
    endgenerate

endmodule
